// File: rtl/gpr_exec_unit.sv
// Clocked GPR execution unit: movsgpr/mov/add/sub/mul on a register file + SGPR.
// Optional EXEC_FLAGS_EN adds a {sign, carry, zero} flags register and port.
module gpr_exec_unit #(
  parameter int DW   = 16,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ir_valid,
  output logic          ir_ready,
  input  logic [31:0]   ir,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] sgpr,
  input  logic [4:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
`ifdef EXEC_FLAGS_EN
  ,
  output logic [2:0]    flags
`endif
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

  state_t            r_state, w_next;
  logic [DW-1:0]     r_gpr [NREG];
  logic [DW-1:0]     r_sgpr;
  logic [DW-1:0]     r_op1, r_op2;
  logic [4:0]        r_oper;
  logic              r_imm;
  logic [AW-1:0]     r_rdst;
  logic [2*DW-1:0]   r_acc, r_mcand;
  logic [DW-1:0]     r_mplier;
  logic [CW-1:0]     r_cnt;
  logic              r_done, r_err;
`ifdef EXEC_FLAGS_EN
  logic [2:0]        r_flags;
`endif

  logic              w_accept;
  logic [AW-1:0]     w_rdst, w_rs1, w_rs2;
  logic [DW-1:0]     w_isrc, w_op2;
  logic [DW:0]       w_sum;
  logic [DW-1:0]     w_res;
  logic              w_carry, w_ill;

  assign ir_ready = (r_state == IDLE);
  assign w_accept = ir_valid && ir_ready;
  assign w_rdst   = ir[22 +: AW];
  assign w_rs1    = ir[17 +: AW];
  assign w_rs2    = ir[11 +: AW];
  assign w_isrc   = DW'(ir[15:0]);
  assign w_op2    = ir[16] ? w_isrc : r_gpr[w_rs2];
  assign w_sum    = {1'b0, r_op1} + {1'b0, r_op2};

  assign done     = r_done;
  assign err      = r_err;
  assign sgpr     = r_sgpr;
  assign dbg_data = r_gpr[dbg_addr[AW-1:0]];
`ifdef EXEC_FLAGS_EN
  assign flags    = r_flags;
`endif

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ill   = 1'b0;
    unique case (r_oper)
      5'd0: w_res = r_sgpr;
      5'd1: w_res = r_imm ? r_op2 : r_op1;
      5'd2: begin
        w_res   = w_sum[DW-1:0];
        w_carry = w_sum[DW];
      end
      5'd3: begin
        w_res   = r_op1 - r_op2;
        w_carry = (r_op1 < r_op2);
      end
      default: w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept)
              w_next = (ir[31:27] == 5'd4) ? MUL : EXEC;
      EXEC: w_next = IDLE;
      MUL:  if (r_cnt == CW'(DW-1)) w_next = WB;
      WB:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      for (int i = 0; i < NREG; i++) r_gpr[i] <= '0;
      r_sgpr   <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_oper   <= '0;
      r_imm    <= 1'b0;
      r_rdst   <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef EXEC_FLAGS_EN
      r_flags  <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      // operands captured here, so rdst==src still sees the old value
      if (w_accept) begin
        r_oper   <= ir[31:27];
        r_imm    <= ir[16];
        r_rdst   <= w_rdst;
        r_op1    <= r_gpr[w_rs1];
        r_op2    <= w_op2;
        r_acc    <= '0;
        r_mcand  <= {{DW{1'b0}}, r_gpr[w_rs1]};
        r_mplier <= w_op2;
        r_cnt    <= '0;
      end
      unique case (r_state)
        EXEC: begin
          r_done <= 1'b1;
          r_err  <= w_ill;
          if (!w_ill) begin
            r_gpr[r_rdst] <= w_res;
`ifdef EXEC_FLAGS_EN
            r_flags <= {w_res[DW-1], w_carry, w_res == '0};
`endif
          end
        end
        MUL: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
        end
        WB: begin
          r_gpr[r_rdst] <= r_acc[DW-1:0];
          r_sgpr        <= r_acc[2*DW-1:DW];
          r_done        <= 1'b1;
`ifdef EXEC_FLAGS_EN
          r_flags <= {r_acc[DW-1], r_acc[2*DW-1:DW] != '0,
                      r_acc[DW-1:0] == '0};
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpr_exec_unit.sv
// Bench for gpr_exec_unit (DW=16, NREG=32): vector table with a scoreboard
// queue, plus hand sequences for held-valid MUL and reset mid-MUL.
module tb_gpr_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir;
  logic        done, err;
  logic [15:0] sgpr, dbg_data;
  logic [4:0]  dbg_addr;
`ifdef EXEC_FLAGS_EN
  logic [2:0]  flags;
`endif

  always #5 clk = ~clk;

  gpr_exec_unit #(.DW(16), .NREG(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready),
    .ir       (ir),
    .done     (done),
    .err      (err),
    .sgpr     (sgpr),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
`ifdef EXEC_FLAGS_EN
    ,
    .flags    (flags)
`endif
  );

  typedef struct {
    logic [31:0] ir;
    logic [4:0]  ra;
    logic [15:0] val;
    logic        e;
    logic [15:0] sg;
    int          lat;
    logic [2:0]  fl;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] mdl [32];
  vec_t        sb [$];
  vec_t        tbl [16];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, x);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op,
    input logic [4:0] rd, input logic [4:0] rs1, input logic imm,
    input logic [15:0] src);
    if (imm) enc = {op, rd, rs1, 1'b1, src};
    else     enc = {op, rd, rs1, 1'b0, src[4:0], 11'd0};
  endfunction

  task automatic run(input vec_t v);
    vec_t e;
    int   lat;
    logic got;
    sb.push_back(v);
    @(negedge clk);
    chk("ready_before", 32'(ir_ready), 32'd1);
    dbg_addr = v.ra;
    ir       = v.ir;
    ir_valid = 1'b1;
    @(posedge clk);
    #1 ir_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      got = done;
    end
    e = sb.pop_front();
    chk("done_seen", 32'(got), 32'd1);
    if (got) begin
      chk("latency", 32'(lat), 32'(e.lat));
      chk("err", 32'(err), 32'(e.e));
      chk("gpr", 32'(dbg_data), 32'(e.val));
      chk("sgpr", 32'(sgpr), 32'(e.sg));
`ifdef EXEC_FLAGS_EN
      chk("flags", 32'(flags), 32'(e.fl));
`endif
      if (!e.e) mdl[e.ra] = e.val;
      @(posedge clk);
      #1 chk("done_pulse", 32'(done), 32'd0);
    end
  endtask

  task automatic all_regs(input string n, input logic use_mdl);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 chk(n, 32'(dbg_data), use_mdl ? 32'(mdl[i]) : 32'd0);
    end
  endtask

  initial begin
    int busy, acc, nd;
    logic fin;
    rst = 1'b1; ir_valid = 1'b0; ir = '0; dbg_addr = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;

    tbl[0]  = '{enc(1, 2, 0, 1, 16'd2),      2,  16'd2,      0, 16'h0,  1, 3'b000};
    tbl[1]  = '{enc(2, 0, 2, 1, 16'd4),      0,  16'd6,      0, 16'h0,  1, 3'b000};
    tbl[2]  = '{enc(1, 4, 0, 1, 16'd5),      4,  16'd5,      0, 16'h0,  1, 3'b000};
    tbl[3]  = '{enc(1, 5, 0, 1, 16'd7),      5,  16'd7,      0, 16'h0,  1, 3'b000};
    tbl[4]  = '{enc(3, 1, 4, 0, 16'd5),      1,  16'hFFFE,   0, 16'h0,  1, 3'b110};
    tbl[5]  = '{enc(1, 3, 0, 1, 16'h1234),   3,  16'h1234,   0, 16'h0,  1, 3'b000};
    tbl[6]  = '{enc(1, 7, 0, 1, 16'h0100),   7,  16'h0100,   0, 16'h0,  1, 3'b000};
    tbl[7]  = '{enc(4, 3, 3, 0, 16'd7),      3,  16'h3400,   0, 16'h12, 17, 3'b010};
    tbl[8]  = '{enc(0, 6, 0, 0, 16'd0),      6,  16'h0012,   0, 16'h12, 1, 3'b000};
    tbl[9]  = '{enc(1, 8, 0, 0, 16'd0),      8,  16'd6,      0, 16'h12, 1, 3'b000};
    tbl[10] = '{enc(2, 9, 1, 1, 16'd5),      9,  16'd3,      0, 16'h12, 1, 3'b010};
    tbl[11] = '{enc(2, 12, 1, 1, 16'h8000),  12, 16'h7FFE,   0, 16'h12, 1, 3'b010};
    tbl[12] = '{enc(2, 13, 1, 1, 16'd2),     13, 16'h0000,   0, 16'h12, 1, 3'b011};
    tbl[13] = '{enc(1, 2, 0, 1, 16'd9),      2,  16'd9,      0, 16'h12, 1, 3'b000};
    tbl[14] = '{enc(2, 2, 2, 0, 16'd2),      2,  16'd18,     0, 16'h12, 1, 3'b000};
    tbl[15] = '{enc(31, 2, 2, 1, 16'h0),     2,  16'd18,     1, 16'h0001, 1, 3'b010};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ir_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_sgpr", 32'(sgpr), 32'd0);
`ifdef EXEC_FLAGS_EN
    chk("rst_flags", 32'(flags), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run(tbl[i]);

    // MUL r10 = r3 * r5 with ir_valid held high throughout
    @(negedge clk);
    ir = enc(4, 10, 3, 0, 16'd5);
    ir_valid = 1'b1;
    busy = 0; acc = 1; fin = 1'b0;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      if (done) begin
        ir_valid = 1'b0;
        fin = 1'b1;
      end else if (!ir_ready) busy++;
      else acc++;
    end
    ir_valid = 1'b0;
    chk("hold_done", 32'(fin), 32'd1);
    chk("hold_busy", 32'(busy), 32'd17);
    chk("hold_accepts", 32'(acc), 32'd1);
    dbg_addr = 5'd10;
    #1 chk("hold_gpr", 32'(dbg_data), 32'h6C00);
    chk("hold_sgpr", 32'(sgpr), 32'h0001);
    mdl[10] = 16'h6C00;

    run(tbl[15]);
    all_regs("illegal_gprs", 1'b1);
    chk("illegal_sgpr", 32'(sgpr), 32'h0001);

    // reset asserted during the 8th MUL cycle
    @(negedge clk);
    ir = enc(4, 11, 3, 0, 16'd7);
    ir_valid = 1'b1;
    @(posedge clk);
    #1 ir_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    nd = 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (done) nd++;
    end
    chk("rst_mid_ready", 32'(ir_ready), 32'd1);
    chk("rst_mid_sgpr", 32'(sgpr), 32'd0);
`ifdef EXEC_FLAGS_EN
    chk("rst_mid_flags", 32'(flags), 32'd0);
`endif
    all_regs("rst_mid_gprs", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 if (done) nd++;
    end
    chk("rst_mid_no_done", 32'(nd), 32'd0);
    dbg_addr = 5'd11;
    #1 chk("rst_mid_r11", 32'(dbg_data), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
